// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath: mode encoding
// and the legal range of input channel counts.
package sc_pkg;

  typedef enum logic {
    MODE_SCALED = 1'b0,
    MODE_SAT    = 1'b1
  } sc_mode_e;

  localparam int NCH_MIN = 2;
  localparam int NCH_MAX = 64;

  function automatic bit nch_legal(input int n);
    return (n >= NCH_MIN) && (n <= NCH_MAX);
  endfunction

endpackage

// File: rtl/usadd_nch_if.sv
// Stream-side signals of the N-channel stochastic adder; the producer
// drives the inputs and consumes oC/oValid.
interface usadd_nch_if #(
  parameter int NCH = 4
);
  logic           iEn;
  logic           iClr;
  logic           iMode;
  logic [NCH-1:0] iBits;
  logic           oC;
  logic           oValid;

  modport master (
    output iEn, iClr, iMode, iBits,
    input  oC, oValid
  );

  modport slave (
    input  iEn, iClr, iMode, iBits,
    output oC, oValid
  );
endinterface

// File: rtl/sc_popcnt.sv
// Combinational popcount built as a balanced adder tree by splitting the
// input in halves until single bits remain.
module sc_popcnt #(
  parameter  int N = 4,
  localparam int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  if (N == 1) begin : g_leaf
    assign count = bits;
  end else begin : g_split
    localparam int NL = N / 2;
    localparam int NR = N - NL;
    localparam int WL = $clog2(NL + 1);
    localparam int WR = $clog2(NR + 1);

    logic [WL-1:0] count_l;
    logic [WR-1:0] count_r;

    sc_popcnt #(.N(NL)) u_lo (
      .bits  (bits[NL-1:0]),
      .count (count_l)
    );

    sc_popcnt #(.N(NR)) u_hi (
      .bits  (bits[N-1:NL]),
      .count (count_r)
    );

    assign count = W'(count_l) + W'(count_r);
  end

endmodule

// File: rtl/usadd_nch.sv
// N-channel unipolar stochastic adder: counts the ones across NCH streams
// and emits one bit per cycle, with a residue accumulator conserving ones.
module usadd_nch
  import sc_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int CNTW = $clog2(NCH + 1),
  localparam int ACCW = $clog2(2 * NCH)
) (
  input  logic        iClk,
  input  logic        iRst,
  usadd_nch_if.slave  bus
);

  if (!nch_legal(NCH)) begin : g_bad_nch
    $error("usadd_nch: NCH=%0d outside legal range %0d..%0d", NCH, NCH_MIN, NCH_MAX);
  end

  localparam logic [ACCW-1:0] NCH_A  = ACCW'(NCH);
  localparam logic [ACCW-1:0] NCH_M1 = ACCW'(NCH - 1);

  logic [CNTW-1:0] pop_cnt;

  logic [CNTW-1:0] cnt_q,   cnt_d;
  sc_mode_e        mode_q,  mode_d;
  logic            v_q,     v_d;
  logic [ACCW-1:0] acc_q,   acc_d;
  logic            c_q,     c_d;
  logic            valid_q, valid_d;

  logic [ACCW-1:0] sum;
  logic [ACCW-1:0] sum_m1;

  sc_popcnt #(.N(NCH)) u_popcnt (
    .bits  (bus.iBits),
    .count (pop_cnt)
  );

  // Stage 1: register the popcount; clear wins over enable.
  always_comb begin
    cnt_d  = '0;
    v_d    = 1'b0;
    mode_d = sc_mode_e'(bus.iMode);
    if (bus.iClr) begin
      mode_d = mode_q;
    end else if (bus.iEn) begin
      cnt_d = pop_cnt;
      v_d   = 1'b1;
    end
  end

  // acc never exceeds NCH-1, so sum fits in ACCW bits without overflow.
  assign sum    = acc_q + ACCW'(cnt_q);
  assign sum_m1 = sum - ACCW'(1);

  always_comb begin
    acc_d   = acc_q;
    c_d     = 1'b0;
    valid_d = 1'b0;
    if (bus.iClr) begin
      acc_d = '0;
    end else if (v_q) begin
      valid_d = 1'b1;
      if (mode_q == MODE_SCALED) begin
        if (sum >= NCH_A) begin
          c_d   = 1'b1;
          acc_d = sum - NCH_A;
        end else begin
          acc_d = sum;
        end
      end else if (sum != '0) begin
        // Excess above NCH-1 is deliberately dropped (saturation).
        c_d   = 1'b1;
        acc_d = (sum_m1 > NCH_M1) ? NCH_M1 : sum_m1;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt_q   <= '0;
      mode_q  <= MODE_SCALED;
      v_q     <= 1'b0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      v_q     <= v_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      valid_q <= valid_d;
    end
  end

  assign bus.oC     = c_q;
  assign bus.oValid = valid_q;

endmodule

// File: doc/usadd_nch.md
# usadd_nch

N-channel unipolar stochastic adder for the SC datapath. Each cycle it consumes one bit from each of NCH input bitstreams, counts the ones, and emits one output bit whose long-run rate is either the scaled sum (Σp/NCH) or the saturated sum (min(1, Σp)). A residue accumulator conserves every input one, so the output is exact over any window up to a bounded residue. It generalises the two-input scaled adder with channel count, a runtime mode, a qualifier, and a synchronous clear.

## Interface
- NCH, 4, number of input bitstreams; legal values are 2..64.
- CNTW, $clog2(NCH+1), popcount width; derived, do not override.
- ACCW, $clog2(2*NCH), accumulator/sum width; derived, do not override.

- iClk  in  1  clock; all state changes on the rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iEn  in  1  input qualifier; iBits and iMode are consumed only when high.
- iClr  in  1  synchronous clear of the accumulator and pipeline.
- iMode  in  1  0 = scaled add; 1 = saturating (non-scaled) add.
- iBits  in  NCH  one bit per input stream.
- oC  out  1  output stochastic bit.
- oValid  out  1  oC carries a result for a consumed input.

## Operation
- **Stage 1 (registered):**
  - rCnt <= popcount(iBits).
  - rMode <= iMode.
  - rV <= iEn.
  - When iEn is 0: rCnt <= 0 and rV <= 0.
- **Stage 2:** sum = acc + rCnt, computed at ACCW bits.
  - Invariant: acc ≤ NCH-1 at all times, so sum ≤ 2·NCH-1 and never overflows.
- **Scaled mode (rMode = 0):**
  - If sum ≥ NCH: oC <= 1, acc <= sum - NCH.
  - Otherwise: oC <= 0, acc <= sum.
  - For NCH = 2 this is bit-identical to the LSB-carry scheme: residue is sum[0], output is sum[1].
- **Saturating mode (rMode = 1):**
  - If sum ≥ 1: oC <= 1, acc <= min(sum - 1, NCH - 1).
  - If sum = 0: oC <= 0, acc unchanged at 0.
  - Clipping at NCH-1 is the intended saturation loss. Each such clip drops the excess ones.
- **rV = 0:**
  - acc holds.
  - oC <= 0, oValid <= 0.
- **rV = 1:** oValid <= 1.
- **Mode switch:** iMode is sampled per input cycle and travels with its count.
  - The residue in acc carries across a switch unchanged.
  - In scaled mode it is still < NCH, so no special handling is needed.
- **iClr:** at the next edge, acc <= 0, rCnt <= 0, rV <= 0, oC <= 0, oValid <= 0.
  - iClr has priority over iEn.
  - The input presented in the iClr cycle is discarded.
- **iRst:** asynchronously forces the following, regardless of clock:
  - acc = 0, rCnt = 0, rV = 0, rMode = 0, oC = 0, oValid = 0.
- **Reset release:** first consumption occurs at the first rising edge with iRst low and iEn high.

## Timing
- Latency: input sampled at edge k → oC/oValid valid after edge k+1, i.e. 2 cycles, registered outputs.
- Throughput is 1 bit per cycle. There is no backpressure.
- oValid is iEn delayed by 2 cycles, except where iClr or iRst intervenes.
- Reset values: oC = 0, oValid = 0.
- Reset asserted mid-stream: the in-flight stage-1 data is lost. No output glitch beyond forcing 0.

## Structure
- **Shared package `sc_pkg`:**
  - Mode encoding MODE_SCALED = 1'b0, MODE_SAT = 1'b1.
  - Legal NCH bounds, NCH_MIN = 2 and NCH_MAX = 64, plus an elaboration check.
- **Sub-module `sc_popcnt #(N)`:** a combinational adder-tree popcount, width $clog2(N+1).
  - It replaces the fixed two-input parallel counter.
  - The stage-1 register lives in usadd_nch, not in the sub-module.
- Target size is roughly 150–250 lines total.

## Test plan
1. **Reset:** assert iRst mid-run with acc ≠ 0 → oC = 0 and oValid = 0 immediately; after release and 2 enabled cycles, the output matches a fresh model (acc = 0).
2. **Scaled, NCH = 4, constant input:**
   - iBits = 4'b1111 → oC = 1 on every valid cycle.
   - iBits = 4'b0001 → oC = 0,0,0,1 repeating; exactly 25 ones in 100 valid cycles.
3. **Saturating, NCH = 4:** iBits = 4'b0011, 4'b0011, then 0 thereafter → oC = 1,1,1,1,0,… (4 ones conserved, no clipping).
   - iBits = 4'b1111 ×2 then 0 → 5 ones total (the clipped excess is lost).
4. **iEn gaps:** drop iEn for 3 cycles mid-stream → oValid low for 3 cycles, shifted by 2, with oC = 0; the subsequent oC sequence is unchanged versus the gap-free run.
5. **iClr and mode switch:**
   - iClr with acc = 3 → next valid output computed with acc = 0.
   - Toggle iMode every 5 cycles → output matches the cycle-accurate model bit-for-bit.
6. **Random regression, NCH ∈ {2, 3, 8, 64}:** random iBits/iEn/iMode for 10k cycles → bit-exact against the behavioural model. In scaled mode, Σinput ones = NCH·Σoutput ones + final acc.
